// File: rtl/clock1_pkg.sv
// Shared opcode/funct encodings and the ALU operation type for the clock1 execute stage.
package clock1_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ZERO,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_PASSB,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLLV,
        ALU_SRLV,
        ALU_SRAV
    } alu_op_t;

endpackage

// File: rtl/clock1_alu.sv
// Combinational ALU for clock1; the barrel shifter exists only when CLOCK1_SHIFT_EN is defined.
module clock1_alu
    import clock1_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_t     op,
    output logic [31:0] result
);

`ifndef CLOCK1_SHIFT_EN
    logic unused_shamt;
    assign unused_shamt = ^shamt;
`endif

    always_comb begin
        result = 32'h0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOR:   result = ~(a | b);
            ALU_SLT:   result = {31'h0, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {31'h0, a < b};
            ALU_PASSB: result = b;
`ifdef CLOCK1_SHIFT_EN
            ALU_SLL:   result = b << shamt;
            ALU_SRL:   result = b >> shamt;
            ALU_SRA:   result = $unsigned($signed(b) >>> shamt);
            ALU_SLLV:  result = b << a[4:0];
            ALU_SRLV:  result = b >> a[4:0];
            ALU_SRAV:  result = $unsigned($signed(b) >>> a[4:0]);
`endif
            default:   result = 32'h0;
        endcase
    end

endmodule

// File: rtl/clock1.sv
// MIPS execute stage: decode, ALU, branch/jump resolution, registered Result/newPC.
// Optional shift functs are enabled with the CLOCK1_SHIFT_EN macro.
module clock1
    import clock1_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Rdata1,
    input  logic [31:0] Rdata2,
    input  logic [31:0] Ed32,
    input  logic [31:0] nextPC,
    output logic [31:0] Result,
    output logic [31:0] newPC
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    alu_op_t     alu_op;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] pc_d;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        unused_regs;

    assign op        = Ins[31:26];
    assign funct     = Ins[5:0];
    assign shamt     = Ins[10:6];
    assign unused_regs = ^Ins[25:16];
    assign br_target = nextPC + {Ed32[29:0], 2'b00};
    assign j_target  = {nextPC[31:28], Ins[25:0], 2'b00};

    always_comb begin
        alu_op = ALU_ZERO;
        alu_b  = Rdata2;
        pc_d   = nextPC;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
`ifdef CLOCK1_SHIFT_EN
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_SLLV: alu_op = ALU_SLLV;
                    FN_SRLV: alu_op = ALU_SRLV;
                    FN_SRAV: alu_op = ALU_SRAV;
`endif
                    FN_JR:   pc_d   = Rdata1;
                    default: alu_op = ALU_ZERO;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                alu_op = ALU_ADD;
                alu_b  = Ed32;
            end
            OP_SLTI: begin
                alu_op = ALU_SLT;
                alu_b  = Ed32;
            end
            OP_SLTIU: begin
                alu_op = ALU_SLTU;
                alu_b  = Ed32;
            end
            // Logical immediates zero-extend rather than use the sign-extended operand.
            OP_ANDI: begin
                alu_op = ALU_AND;
                alu_b  = {16'h0, Ins[15:0]};
            end
            OP_ORI: begin
                alu_op = ALU_OR;
                alu_b  = {16'h0, Ins[15:0]};
            end
            OP_XORI: begin
                alu_op = ALU_XOR;
                alu_b  = {16'h0, Ins[15:0]};
            end
            OP_LUI: begin
                alu_op = ALU_PASSB;
                alu_b  = {Ins[15:0], 16'h0};
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                if (Rdata1 == Rdata2) pc_d = br_target;
            end
            OP_BNE: begin
                alu_op = ALU_SUB;
                if (Rdata1 != Rdata2) pc_d = br_target;
            end
            OP_J: pc_d = j_target;
            // Link value travels through the ALU as a pass-through of nextPC.
            OP_JAL: begin
                alu_op = ALU_PASSB;
                alu_b  = nextPC;
                pc_d   = j_target;
            end
            default: alu_op = ALU_ZERO;
        endcase
    end

    clock1_alu u_alu (
        .a      (Rdata1),
        .b      (alu_b),
        .shamt  (shamt),
        .op     (alu_op),
        .result (alu_y)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Result <= 32'h0;
            newPC  <= 32'h0;
        end else begin
            Result <= alu_y;
            newPC  <= pc_d;
        end
    end

endmodule

// File: tb/tb_clock1.sv
// Directed self-checking bench for the clock1 execute stage.
module tb_clock1;

    logic        CLK;
    logic        RST;
    logic [31:0] Ins;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic [31:0] Ed32;
    logic [31:0] nextPC;
    logic [31:0] Result;
    logic [31:0] newPC;

    int checks;
    int failures;

    clock1 dut (
        .CLK    (CLK),
        .RST    (RST),
        .Ins    (Ins),
        .Rdata1 (Rdata1),
        .Rdata2 (Rdata2),
        .Ed32   (Ed32),
        .nextPC (nextPC),
        .Result (Result),
        .newPC  (newPC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input logic [31:0] npc);
        Ins    = ins;
        Rdata1 = a;
        Rdata2 = b;
        Ed32   = ed;
        nextPC = npc;
    endtask

    // Apply a vector mid-cycle, then sample 1 time unit after the capturing edge.
    task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic [31:0] npc);
        @(negedge CLK);
        drive(ins, a, b, ed, npc);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset with live inputs: outputs must clear immediately and stay clear.
        RST = 1'b1;
        drive(32'h0000_0020, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0, 32'h0040_0000);
        #2;
        RST = 1'b0;
        #1;
        check("reset_result_async", Result, 32'h0);
        check("reset_newpc_async", newPC, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check("reset_result_hold", Result, 32'h0);
        check("reset_newpc_hold", newPC, 32'h0);

        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("release_no_update", Result, 32'h0);
        @(posedge CLK);
        #1;
        check("add_result", Result, 32'h0000_0002);
        check("add_newpc", newPC, 32'h0040_0000);

        step(32'h0000_0021, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h0040_0004);
        check("addu_overflow", Result, 32'h8000_0000);
        check("addu_newpc", newPC, 32'h0040_0004);

        step(32'h0000_0022, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0040_0008);
        check("sub_result", Result, 32'hFFFF_FFFE);

        step(32'h0000_002A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0040_000C);
        check("slt_result", Result, 32'h0000_0001);

        step(32'h0000_002B, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0040_0010);
        check("sltu_result", Result, 32'h0000_0000);

        step(32'h2800_FFFF, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0040_0014);
        check("slti_result", Result, 32'h0000_0000);

        step(32'h2C00_FFFF, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0040_0018);
        check("sltiu_result", Result, 32'h0000_0001);

        step(32'h3000_FFFF, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h0040_001C);
        check("andi_zext", Result, 32'h0000_5678);

        step(32'h3C00_ABCD, 32'h1111_1111, 32'h0, 32'hFFFF_ABCD, 32'h0040_0020);
        check("lui_result", Result, 32'hABCD_0000);

        step(32'h8C00_FFFC, 32'h1000_0010, 32'h0, 32'hFFFF_FFFC, 32'h0040_0024);
        check("lw_addr", Result, 32'h1000_000C);

        step(32'h1000_FFFE, 32'h0000_0007, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0040_0004);
        check("beq_taken_pc", newPC, 32'h003F_FFFC);
        check("beq_taken_result", Result, 32'h0000_0000);

        step(32'h1000_FFFE, 32'h0000_0007, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0040_0004);
        check("beq_not_taken_pc", newPC, 32'h0040_0004);
        check("beq_not_taken_result", Result, 32'h0000_0004);

        step(32'h1400_0003, 32'h0000_0007, 32'h0000_0003, 32'h0000_0003, 32'h0040_0100);
        check("bne_taken_pc", newPC, 32'h0040_010C);

        step(32'h0C10_0010, 32'hDEAD_BEEF, 32'h0, 32'h0000_0010, 32'h0040_0008);
        check("jal_newpc", newPC, 32'h0040_0040);
        check("jal_result", Result, 32'h0040_0008);

        step(32'h0810_0010, 32'h0, 32'h0, 32'h0000_0010, 32'h9040_0008);
        check("j_newpc", newPC, 32'h9040_0040);
        check("j_result", Result, 32'h0000_0000);

        step(32'h0000_0008, 32'h0000_1234, 32'h5555_5555, 32'h0, 32'h0040_0030);
        check("jr_newpc", newPC, 32'h0000_1234);
        check("jr_result", Result, 32'h0000_0000);

        step(32'h0000_0103, 32'h0, 32'h8000_0000, 32'h0, 32'h0040_0034);
`ifdef CLOCK1_SHIFT_EN
        check("sra_result", Result, 32'hF800_0000);
`else
        check("sra_disabled", Result, 32'h0000_0000);
`endif
        check("sra_newpc", newPC, 32'h0040_0034);

        step(32'hFC00_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0040_0038);
        check("unknown_result", Result, 32'h0000_0000);
        check("unknown_newpc", newPC, 32'h0040_0038);

        // Mid-stream reset: in-flight instruction is discarded, outputs clear at once.
        step(32'h0000_0025, 32'h0F0F_0000, 32'h0000_00F0, 32'h0, 32'h0040_003C);
        check("or_result", Result, 32'h0F0F_00F0);
        @(negedge CLK);
        drive(32'h0000_0020, 32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0040_0040);
        #1;
        RST = 1'b0;
        #1;
        check("midreset_result", Result, 32'h0);
        check("midreset_newpc", newPC, 32'h0);
        @(posedge CLK);
        #1;
        check("midreset_hold", newPC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
